// File: rtl/membrane_spike_encoder.sv
// membrane_spike_encoder
// Takes one set of updated neuron membranes and compares each against a signed
// threshold. It returns post-fire membranes for SRAM writeback as a one-cycle strobe,
// then sends fired neuron indices as AER events in ascending order over valid/ready.
// Optional build macro: SOFT_RESET_EN. When it is defined, fired neurons are written
// back as (membrane - threshold). When it is undefined, fired neurons are written back as 0.
module membrane_spike_encoder #(
  parameter int unsigned BIT_WIDTH_MEMBRANE = 17,
  parameter int unsigned NEURON_NUM_IN_SET  = 20,
  parameter int unsigned BIT_WIDTH_INDEX    = 5,
  parameter int unsigned BIT_WIDTH_SET_ID   = 8
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             set_valid_i,
  output logic                                             set_ready_o,
  input  logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0]  membrane_i,
  input  logic [BIT_WIDTH_SET_ID-1:0]                      set_id_i,
  input  logic [BIT_WIDTH_MEMBRANE-1:0]                    threshold_i,
  output logic                                             membrane_wb_valid_o,
  output logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0]  membrane_wb_o,
  output logic [BIT_WIDTH_SET_ID-1:0]                      membrane_wb_set_id_o,
  output logic [BIT_WIDTH_INDEX:0]                         fire_count_o,
  output logic                                             spike_valid_o,
  input  logic                                             spike_ready_i,
  output logic [BIT_WIDTH_SET_ID+BIT_WIDTH_INDEX-1:0]      spike_addr_o,
  output logic                                             spike_last_o
);

  localparam int unsigned W  = BIT_WIDTH_MEMBRANE;
  localparam int unsigned N  = NEURON_NUM_IN_SET;
  localparam int unsigned IW = BIT_WIDTH_INDEX;
  localparam int unsigned SW = BIT_WIDTH_SET_ID;
  localparam int unsigned CW = BIT_WIDTH_INDEX + 1;
  localparam int unsigned AW = BIT_WIDTH_SET_ID + BIT_WIDTH_INDEX;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  // Index of the lowest set bit. The result is 0 for an empty mask, which the callers never pass.
  function automatic logic [IW-1:0] lowest_idx(input logic [N-1:0] m);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Number of set bits in a fire mask.
  function automatic logic [CW-1:0] popcount(input logic [N-1:0] m);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(m[i]);
    end
    return cnt;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic is_onehot(input logic [N-1:0] m);
    return (m != '0) && ((m & (m - N'(1))) == '0);
  endfunction

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [SW-1:0]   set_id_q, set_id_d;
  logic            set_ready_q, set_ready_d;
  logic            wb_valid_q, wb_valid_d;
  logic [W*N-1:0]  wb_data_q, wb_data_d;
  logic [CW-1:0]   fire_count_q, fire_count_d;
  logic            spike_valid_q, spike_valid_d;
  logic [AW-1:0]   spike_addr_q, spike_addr_d;
  logic            spike_last_q, spike_last_d;

  logic [N-1:0]    accept_mask_c;
  logic [W*N-1:0]  accept_wb_c;
  logic [CW-1:0]   accept_count_c;
  logic [N-1:0]    mask_next_c;

  // Threshold compare and post-fire membrane values for the set currently offered.
  always_comb begin
    accept_mask_c = '0;
    accept_wb_c   = membrane_i;
    for (int i = 0; i < N; i++) begin
      if ($signed(membrane_i[i*W +: W]) >= $signed(threshold_i)) begin
        accept_mask_c[i] = 1'b1;
`ifdef SOFT_RESET_EN
        accept_wb_c[i*W +: W] = membrane_i[i*W +: W] - threshold_i;
`else
        accept_wb_c[i*W +: W] = '0;
`endif
      end
    end
    accept_count_c = popcount(accept_mask_c);
  end

  // Next-state and next-output logic for the accept / writeback / emit sequence.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    set_id_d      = set_id_q;
    set_ready_d   = set_ready_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    fire_count_d  = fire_count_q;
    spike_valid_d = spike_valid_q;
    spike_addr_d  = spike_addr_q;
    spike_last_d  = spike_last_q;
    // Mask with the lowest set bit removed: the bit for the event being handed off.
    mask_next_c   = mask_q & (mask_q - N'(1));

    case (state_q)
      IDLE: begin
        set_ready_d = 1'b1;
        if (set_valid_i) begin
          state_d      = WB;
          set_ready_d  = 1'b0;
          mask_d       = accept_mask_c;
          set_id_d     = set_id_i;
          wb_valid_d   = 1'b1;
          wb_data_d    = accept_wb_c;
          fire_count_d = accept_count_c;
        end
      end

      WB: begin
        if (mask_q != '0) begin
          state_d       = EMIT;
          spike_valid_d = 1'b1;
          spike_addr_d  = {set_id_q, lowest_idx(mask_q)};
          spike_last_d  = is_onehot(mask_q);
        end else begin
          state_d     = IDLE;
          set_ready_d = 1'b1;
        end
      end

      EMIT: begin
        if (spike_ready_i) begin
          mask_d = mask_next_c;
          if (mask_next_c == '0) begin
            state_d       = IDLE;
            set_ready_d   = 1'b1;
            spike_valid_d = 1'b0;
            spike_last_d  = 1'b0;
          end else begin
            spike_addr_d = {set_id_q, lowest_idx(mask_next_c)};
            spike_last_d = is_onehot(mask_next_c);
          end
        end
      end

      default: begin
        state_d       = IDLE;
        mask_d        = '0;
        set_ready_d   = 1'b1;
        spike_valid_d = 1'b0;
        spike_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      set_id_q      <= '0;
      set_ready_q   <= 1'b1;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      fire_count_q  <= '0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      spike_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      set_id_q      <= set_id_d;
      set_ready_q   <= set_ready_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      fire_count_q  <= fire_count_d;
      spike_valid_q <= spike_valid_d;
      spike_addr_q  <= spike_addr_d;
      spike_last_q  <= spike_last_d;
    end
  end

  assign set_ready_o          = set_ready_q;
  assign membrane_wb_valid_o  = wb_valid_q;
  assign membrane_wb_o        = wb_data_q;
  assign membrane_wb_set_id_o = set_id_q;
  assign fire_count_o         = fire_count_q;
  assign spike_valid_o        = spike_valid_q;
  assign spike_addr_o         = spike_addr_q;
  assign spike_last_o         = spike_last_q;

endmodule

// File: tb/tb_membrane_spike_encoder.sv
// Directed bench for membrane_spike_encoder, default parameters.
// Honors SOFT_RESET_EN for the expected writeback values of fired neurons.
module tb_membrane_spike_encoder;

  localparam int unsigned W  = 17;
  localparam int unsigned N  = 20;
  localparam int unsigned IW = 5;
  localparam int unsigned SW = 8;
`ifdef SOFT_RESET_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              set_valid_i;
  logic              set_ready_o;
  logic [W*N-1:0]    membrane_i;
  logic [SW-1:0]     set_id_i;
  logic [W-1:0]      threshold_i;
  logic              membrane_wb_valid_o;
  logic [W*N-1:0]    membrane_wb_o;
  logic [SW-1:0]     membrane_wb_set_id_o;
  logic [IW:0]       fire_count_o;
  logic              spike_valid_o;
  logic              spike_ready_i;
  logic [SW+IW-1:0]  spike_addr_o;
  logic              spike_last_o;

  logic [W-1:0] mem [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) membrane_i[i*W +: W] = mem[i];
  end

  membrane_spike_encoder dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .set_valid_i          (set_valid_i),
    .set_ready_o          (set_ready_o),
    .membrane_i           (membrane_i),
    .set_id_i             (set_id_i),
    .threshold_i          (threshold_i),
    .membrane_wb_valid_o  (membrane_wb_valid_o),
    .membrane_wb_o        (membrane_wb_o),
    .membrane_wb_set_id_o (membrane_wb_set_id_o),
    .fire_count_o         (fire_count_o),
    .spike_valid_o        (spike_valid_o),
    .spike_ready_i        (spike_ready_i),
    .spike_addr_o         (spike_addr_o),
    .spike_last_o         (spike_last_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] wb_word(input int i);
    return membrane_wb_o[i*W +: W];
  endfunction

  function automatic logic [SW+IW-1:0] addr_of(input logic [SW-1:0] id, input int idx);
    logic [IW-1:0] ix;
    ix = IW'(idx);
    return {id, ix};
  endfunction

  // Offer a set at a negedge. The task returns at the negedge of the writeback cycle.
  // After the accept it changes threshold and id to show that they are ignored.
  task automatic accept_set(input logic [SW-1:0] id, input logic [W-1:0] thr);
    check_eq("ready_before_accept", 64'(set_ready_o), 64'd1);
    set_valid_i = 1'b1;
    set_id_i    = id;
    threshold_i = thr;
    @(negedge clk);
    set_valid_i = 1'b0;
    set_id_i    = 8'hFF;
    threshold_i = 17'd1;
    check_eq("wb_valid_strobe", 64'(membrane_wb_valid_o), 64'd1);
    check_eq("wb_set_id", 64'(membrane_wb_set_id_o), 64'(id));
    check_eq("ready_in_wb", 64'(set_ready_o), 64'd0);
  endtask

  task automatic expect_spike(input string tag, input logic [SW-1:0] id, input int idx, input bit last);
    check_eq({tag, "_valid"}, 64'(spike_valid_o), 64'd1);
    check_eq({tag, "_addr"}, 64'(spike_addr_o), 64'(addr_of(id, idx)));
    check_eq({tag, "_last"}, 64'(spike_last_o), 64'(last));
  endtask

  task automatic load_set2();
    for (int i = 0; i < N; i++) mem[i] = -17'sd5;
    mem[3]  = 17'd150;
    mem[7]  = 17'd100;
    mem[19] = 17'd99;
  endtask

  initial begin
    reset_n       = 1'b0;
    set_valid_i   = 1'b0;
    spike_ready_i = 1'b0;
    set_id_i      = '0;
    threshold_i   = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset held for two edges
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(set_ready_o), 64'd1);
    check_eq("rst_spike_valid", 64'(spike_valid_o), 64'd0);
    check_eq("rst_wb_valid", 64'(membrane_wb_valid_o), 64'd0);
    check_eq("rst_fire_count", 64'(fire_count_o), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Two neurons fire at the threshold boundary; sink always ready
    load_set2();
    spike_ready_i = 1'b1;
    accept_set(8'h2A, 17'd100);
    check_eq("t2_fire_count", 64'(fire_count_o), 64'd2);
    check_eq("t2_wb_n3", 64'(wb_word(3)), SOFT ? 64'd50 : 64'd0);
    check_eq("t2_wb_n7", 64'(wb_word(7)), 64'd0);
    check_eq("t2_wb_n19", 64'(wb_word(19)), 64'd99);
    check_eq("t2_wb_n0", 64'(wb_word(0)), 64'h1FFFB);
    @(negedge clk);
    check_eq("t2_wb_one_cycle", 64'(membrane_wb_valid_o), 64'd0);
    expect_spike("t2_s0", 8'h2A, 3, 1'b0);
    @(negedge clk);
    expect_spike("t2_s1", 8'h2A, 7, 1'b1);
    @(negedge clk);
    check_eq("t2_done_valid", 64'(spike_valid_o), 64'd0);
    check_eq("t2_done_ready", 64'(set_ready_o), 64'd1);

    // Same set with backpressure on the first event
    spike_ready_i = 1'b0;
    accept_set(8'h2A, 17'd100);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expect_spike("t3_hold", 8'h2A, 3, 1'b0);
    end
    spike_ready_i = 1'b1;
    @(negedge clk);
    expect_spike("t3_s1", 8'h2A, 7, 1'b1);
    @(negedge clk);
    check_eq("t3_done_valid", 64'(spike_valid_o), 64'd0);
    check_eq("t3_done_ready", 64'(set_ready_o), 64'd1);

    // No neuron reaches the threshold: large negative values and thr-1
    for (int i = 0; i < N; i++) mem[i] = (i % 2 == 0) ? 17'h10000 : 17'd99;
    accept_set(8'h05, 17'd100);
    check_eq("t4_fire_count", 64'(fire_count_o), 64'd0);
    check_eq("t4_wb_n0", 64'(wb_word(0)), 64'h10000);
    check_eq("t4_wb_n5", 64'(wb_word(5)), 64'd99);
    @(negedge clk);
    check_eq("t4_no_spike", 64'(spike_valid_o), 64'd0);
    check_eq("t4_ready_t2", 64'(set_ready_o), 64'd1);

    // All twenty neurons fire back to back
    for (int i = 0; i < N; i++) mem[i] = 17'd200;
    accept_set(8'h11, 17'd100);
    check_eq("t5_fire_count", 64'(fire_count_o), 64'd20);
    check_eq("t5_wb_n19", 64'(wb_word(19)), SOFT ? 64'd100 : 64'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      expect_spike("t5", 8'h11, i, i == N - 1);
    end
    @(negedge clk);
    check_eq("t5_done_valid", 64'(spike_valid_o), 64'd0);
    check_eq("t5_done_ready", 64'(set_ready_o), 64'd1);

    // Reset partway through emission, after two of five events
    for (int i = 0; i < N; i++) mem[i] = 17'd3;
    mem[1] = 17'd10; mem[4] = 17'd10; mem[6] = 17'd10; mem[9] = 17'd10; mem[15] = 17'd10;
    accept_set(8'h33, 17'd10);
    check_eq("t6_fire_count", 64'(fire_count_o), 64'd5);
    @(negedge clk);
    expect_spike("t6_s0", 8'h33, 1, 1'b0);
    @(negedge clk);
    expect_spike("t6_s1", 8'h33, 4, 1'b0);
    @(negedge clk);
    expect_spike("t6_s2", 8'h33, 6, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_valid", 64'(spike_valid_o), 64'd0);
    check_eq("t6_rst_ready", 64'(set_ready_o), 64'd1);
    check_eq("t6_rst_wb", 64'(membrane_wb_valid_o), 64'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("t6_quiet", 64'(spike_valid_o), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
